// File: rtl/exa_crosb_input_vc_arbiter.sv
// rtl/exa_crosb_input_vc_arbiter.sv - per-input-port VC scheduler for the crossbar e2s stage
module exa_crosb_input_vc_arbiter #(
    parameter int prio_num     = 2,
    parameter int vc_num       = 2,
    parameter int output_num   = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int PV          = prio_num * vc_num,
    localparam int logVcPrio   = (PV > 1) ? $clog2(PV) : 1,
    localparam int logOutput   = (output_num > 1) ? $clog2(output_num) : 1,
    localparam int logPrio     = (prio_num > 1) ? $clog2(prio_num) : 1
) (
    input  logic                           M_ACLK,
    input  logic                           M_ARESETN,
    input  logic [PV-1:0]                  i_has_packet,
    input  logic [PV*logOutput-1:0]        i_dests,
    input  logic [PV*logVcPrio-1:0]        i_output_vc,
    input  logic [output_num*PV-1:0]       i_out_vc_avail,
    input  logic                           i_tready,
    input  logic                           i_tlast,
    output logic [logVcPrio-1:0]           o_selected_vc,
    output logic                           o_cts,
    output logic                           o_busy,
    output logic [logPrio-1:0]             o_grant_prio
);

    localparam int LOG_VC   = (vc_num > 1) ? $clog2(vc_num) : 1;
    localparam int AVAIL_W  = (output_num * PV > 1) ? $clog2(output_num * PV) : 1;
    localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [logVcPrio-1:0] sel_q, sel_d;
    logic [logPrio-1:0]   prio_q, prio_d;
    logic [LOG_VC-1:0]    ptr_q [prio_num];
    logic [LOG_VC-1:0]    ptr_d [prio_num];
    logic [STARVE_W-1:0]  starve_q, starve_d;

    // Eligibility and its per-class view
    logic [PV-1:0]        eligible;
    logic [logOutput-1:0] head_dest;
    logic [logVcPrio-1:0] head_ovc;
    logic [AVAIL_W-1:0]   avail_idx;
    logic [vc_num-1:0]    elig_cls [prio_num];
    logic [prio_num-1:0]  class_any;

    // Pick results
    logic [logPrio-1:0]   top_cls;
    logic [logPrio-1:0]   low_cls;
    logic                 low_found;
    logic                 starve_fire;
    logic [logPrio-1:0]   pick_cls;
    logic [vc_num-1:0]    cls_vec;
    logic [LOG_VC-1:0]    win_i;
    logic [LOG_VC-1:0]    cand;
    logic                 win_found;
    logic [logVcPrio-1:0] win_vc;
    logic [STARVE_W-1:0]  starve_upd;

    // A VC is eligible when its FIFO holds a packet and the head's target output VC has room
    always_comb begin
        eligible  = '0;
        head_dest = '0;
        head_ovc  = '0;
        avail_idx = '0;
        for (int v = 0; v < PV; v++) begin
            head_dest   = i_dests[v*logOutput +: logOutput];
            head_ovc    = i_output_vc[v*logVcPrio +: logVcPrio];
            avail_idx   = AVAIL_W'(head_dest) * AVAIL_W'(PV) + AVAIL_W'(head_ovc);
            eligible[v] = i_has_packet[v] & i_out_vc_avail[avail_idx];
        end
    end

    // Regroup eligibility by priority class so the round-robin can index one class
    always_comb begin
        elig_cls  = '{default: '0};
        class_any = '0;
        for (int j = 0; j < prio_num; j++) begin
            for (int i = 0; i < vc_num; i++) begin
                elig_cls[j][i] = eligible[j*vc_num + i];
            end
            class_any[j] = |elig_cls[j];
        end
    end

    // Winner selection: highest class unless the starvation guard hands the slot down
    always_comb begin
        top_cls   = '0;
        low_cls   = '0;
        low_found = 1'b0;
        for (int j = 0; j < prio_num; j++) begin
            if (class_any[j]) begin
                top_cls = logPrio'(j);
            end
        end
        // Highest eligible class strictly below the top one
        for (int j = 0; j < prio_num; j++) begin
            if (class_any[j] && (logPrio'(j) < top_cls)) begin
                low_cls   = logPrio'(j);
                low_found = 1'b1;
            end
        end

        starve_fire = (STARVE_LIMIT != 0) && (starve_q == STARVE_MAX) && low_found;
        pick_cls    = starve_fire ? low_cls : top_cls;
        cls_vec     = elig_cls[pick_cls];

        // Round-robin: first eligible VC after the class pointer, wrapping around
        win_i     = ptr_q[pick_cls];
        win_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= vc_num; k++) begin
            cand = LOG_VC'((int'(ptr_q[pick_cls]) + k) % vc_num);
            if (!win_found && cls_vec[cand]) begin
                win_i     = cand;
                win_found = 1'b1;
            end
        end
        win_vc = logVcPrio'(int'(pick_cls) * vc_num + int'(win_i));

        // Count consecutive top-class grants that bypassed a waiting lower class
        if ((pick_cls == top_cls) && low_found) begin
            starve_upd = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_W'(1);
        end else begin
            starve_upd = '0;
        end
    end

    // Next-state logic: grant from IDLE, release the port on the last-beat handshake
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        prio_d   = prio_q;
        ptr_d    = ptr_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d         = XFER;
                    sel_d           = win_vc;
                    prio_d          = pick_cls;
                    ptr_d[pick_cls] = win_i;
                    starve_d        = starve_upd;
                end
            end
            XFER: begin
                if (o_cts && i_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, selection, round-robin pointers and starvation counter
    always_ff @(posedge M_ACLK or negedge M_ARESETN) begin
        if (!M_ARESETN) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            prio_q   <= '0;
            ptr_q    <= '{default: '0};
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            prio_q   <= prio_d;
            ptr_q    <= ptr_d;
            starve_q <= starve_d;
        end
    end

    // Dequeue strobe is the beat handshake; an empty FIFO simply stalls the packet
    assign o_busy        = (state_q == XFER);
    assign o_cts         = o_busy & i_has_packet[sel_q] & i_tready;
    assign o_selected_vc = sel_q;
    assign o_grant_prio  = prio_q;

endmodule

// File: tb/tb_exa_crosb_input_vc_arbiter.sv
// tb/tb_exa_crosb_input_vc_arbiter.sv - self-checking bench for exa_crosb_input_vc_arbiter
module tb_exa_crosb_input_vc_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  has_packet;
    logic [7:0]  dests;
    logic [7:0]  output_vc;
    logic [15:0] out_vc_avail;
    logic        tready;
    logic        tlast;

    logic [1:0]  sel_s, sel_p;
    logic        cts_s, cts_p, busy_s, busy_p;
    logic        gp_s, gp_p;

    int n_cmp  = 0;
    int n_fail = 0;

    // model state, index 0 = starvation-limited instance, 1 = strict-priority instance
    int lim [2] = '{2, 0};
    int m_busy [2];
    int m_sel [2];
    int m_prio [2];
    int m_starve [2];
    int m_ptr [2][2];

    always #5 clk = ~clk;

    exa_crosb_input_vc_arbiter #(
        .prio_num(2), .vc_num(2), .output_num(4), .STARVE_LIMIT(2)
    ) dut_s (
        .M_ACLK(clk), .M_ARESETN(rst_n),
        .i_has_packet(has_packet), .i_dests(dests), .i_output_vc(output_vc),
        .i_out_vc_avail(out_vc_avail), .i_tready(tready), .i_tlast(tlast),
        .o_selected_vc(sel_s), .o_cts(cts_s), .o_busy(busy_s), .o_grant_prio(gp_s)
    );

    exa_crosb_input_vc_arbiter #(
        .prio_num(2), .vc_num(2), .output_num(4), .STARVE_LIMIT(0)
    ) dut_p (
        .M_ACLK(clk), .M_ARESETN(rst_n),
        .i_has_packet(has_packet), .i_dests(dests), .i_output_vc(output_vc),
        .i_out_vc_avail(out_vc_avail), .i_tready(tready), .i_tlast(tlast),
        .o_selected_vc(sel_p), .o_cts(cts_p), .o_busy(busy_p), .o_grant_prio(gp_p)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit elig(input int v);
        int d;
        int o;
        d = int'(dests[v*2 +: 2]);
        o = int'(output_vc[v*2 +: 2]);
        return has_packet[v] && out_vc_avail[d*4 + o];
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k]   = 0;
            m_sel[k]    = 0;
            m_prio[k]   = 0;
            m_starve[k] = 0;
            m_ptr[k][0] = 0;
            m_ptr[k][1] = 0;
        end
    endtask

    task automatic m_step(input int k);
        int top;
        int low;
        int cls;
        int win;
        int p;
        if (m_busy[k] != 0) begin
            if (has_packet[m_sel[k]] && tready && tlast) m_busy[k] = 0;
            return;
        end
        top = -1;
        low = -1;
        for (int j = 1; j >= 0; j--)
            if (top < 0 && (elig(j*2) || elig(j*2+1))) top = j;
        if (top < 0) return;
        for (int j = top - 1; j >= 0; j--)
            if (low < 0 && (elig(j*2) || elig(j*2+1))) low = j;
        cls = top;
        if (lim[k] != 0 && m_starve[k] == lim[k] && low >= 0) begin
            cls = low;
            m_starve[k] = 0;
        end else if (low >= 0) begin
            m_starve[k] = (m_starve[k] < lim[k]) ? m_starve[k] + 1 : lim[k];
        end else begin
            m_starve[k] = 0;
        end
        win = -1;
        for (int s = 1; s <= 2; s++) begin
            p = (m_ptr[k][cls] + s) % 2;
            if (win < 0 && elig(cls*2 + p)) win = p;
        end
        m_ptr[k][cls] = win;
        m_sel[k]      = cls*2 + win;
        m_prio[k]     = cls;
        m_busy[k]     = 1;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
            end else begin
                m_step(0);
                m_step(1);
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("busy_s", int'(busy_s), m_busy[0]);
            chk("busy_p", int'(busy_p), m_busy[1]);
            chk("cts_s", int'(cts_s), int'(m_busy[0] != 0 && has_packet[m_sel[0]] && tready));
            chk("cts_p", int'(cts_p), int'(m_busy[1] != 0 && has_packet[m_sel[1]] && tready));
            chk("sel_s", int'(sel_s), m_sel[0]);
            chk("sel_p", int'(sel_p), m_sel[1]);
            chk("prio_s", int'(gp_s), m_prio[0]);
            chk("prio_p", int'(gp_p), m_prio[1]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        has_packet   = '0;
        dests        = '0;
        output_vc    = '0;
        out_vc_avail = '1;
        tready       = 1'b1;
        tlast        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    int beats;
    int done;
    int seq_s [$];
    int seq_p [$];
    int exp3 [4]  = '{3, 2, 3, 2};
    int exp5s [6] = '{3, 3, 0, 3, 3, 0};

    initial begin
        idle_inputs();

        // 1: idle after reset with nothing queued
        do_reset();
        for (int c = 0; c < 10; c++) begin
            chk("t1_busy", int'(busy_p), 0);
            chk("t1_cts", int'(cts_p), 0);
            chk("t1_busy_s", int'(busy_s), 0);
            cyc();
        end

        // 2: VC0 and VC2 eligible, higher class wins, 3-beat packet then 1-cycle gap
        do_reset();
        has_packet = 4'b0101;
        cyc();
        chk("t2_sel", int'(sel_p), 2);
        chk("t2_prio", int'(gp_p), 1);
        chk("t2_busy", int'(busy_p), 1);
        beats = 0;
        done  = 0;
        for (int c = 0; c < 20 && done == 0; c++) begin
            tlast = (beats == 2);
            #1;
            if (cts_p) beats++;
            if (cts_p && tlast) done = 1;
            cyc();
        end
        chk("t2_beats", beats, 3);
        chk("t2_done", done, 1);
        chk("t2_gap", int'(busy_p), 0);
        tlast = 1'b0;
        cyc();
        chk("t2_regrant", int'(busy_p), 1);

        // 3: two VCs of the same class alternate on 1-beat packets
        do_reset();
        has_packet = 4'b1100;
        tlast      = 1'b1;
        seq_s.delete();
        seq_p.delete();
        for (int c = 0; c < 40 && seq_p.size() < 4; c++) begin
            if (cts_s) seq_s.push_back(int'(sel_s));
            if (cts_p) seq_p.push_back(int'(sel_p));
            cyc();
        end
        chk("t3_count", seq_p.size(), 4);
        for (int i = 0; i < 4 && i < seq_p.size(); i++) begin
            chk("t3_seq_p", seq_p[i], exp3[i]);
            chk("t3_seq_s", seq_s[i], exp3[i]);
        end

        // 4: VC0 blocked by a full downstream output VC until it frees up
        do_reset();
        dests[1:0]      = 2'd1;
        output_vc[1:0]  = 2'd0;
        out_vc_avail[4] = 1'b0;
        has_packet      = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("t4_blocked", int'(busy_p), 0);
        end
        out_vc_avail[4] = 1'b1;
        cyc();
        chk("t4_busy", int'(busy_p), 1);
        chk("t4_sel", int'(sel_p), 0);

        // 5: starvation guard lets the lower class through every third grant
        do_reset();
        has_packet = 4'b1001;
        tlast      = 1'b1;
        seq_s.delete();
        seq_p.delete();
        for (int c = 0; c < 40 && seq_s.size() < 6; c++) begin
            if (cts_s) seq_s.push_back(int'(sel_s));
            if (cts_p) seq_p.push_back(int'(sel_p));
            cyc();
        end
        chk("t5_count", seq_s.size(), 6);
        for (int i = 0; i < 6 && i < seq_s.size(); i++) begin
            chk("t5_seq_s", seq_s[i], exp5s[i]);
            chk("t5_seq_p", seq_p[i], 3);
        end

        // 6: backpressure, underflow, late avail change, stray tlast, async reset in XFER
        do_reset();
        has_packet = 4'b0010;
        cyc();
        chk("t6_busy", int'(busy_p), 1);
        chk("t6_sel", int'(sel_p), 1);
        #1 chk("t6_cts_a", int'(cts_p), 1);
        cyc();
        tready = 1'b0;
        #1 chk("t6_cts_b", int'(cts_p), 0);
        cyc();
        tready       = 1'b1;
        out_vc_avail = '0;
        #1 chk("t6_cts_c", int'(cts_p), 1);
        cyc();
        has_packet = 4'b0000;
        #1 chk("t6_underflow", int'(cts_p), 0);
        cyc();
        chk("t6_hold", int'(busy_p), 1);
        has_packet = 4'b0010;
        tready     = 1'b0;
        tlast      = 1'b1;
        #1 chk("t6_cts_d", int'(cts_p), 0);
        cyc();
        chk("t6_stray_tlast", int'(busy_p), 1);
        tready = 1'b1;
        #1 chk("t6_cts_e", int'(cts_p), 1);
        cyc();
        chk("t6_end", int'(busy_p), 0);
        out_vc_avail = '1;
        tlast        = 1'b0;
        cyc();
        chk("t6_regrant", int'(busy_p), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", int'(busy_p), 0);
        chk("t6_rst_cts", int'(cts_p), 0);
        chk("t6_rst_busy_s", int'(busy_s), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
